// File: rtl/wb_arbiter.sv
// Writeback arbiter: sole writer of the register-file port, merging ALU results
// with FIFO-buffered LSU results and tracking per-register pending LSU writes.
module wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [4:0]               lsu_rd,
    input  logic [XLEN-1:0]          lsu_data,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_rd,
    output logic [31:0]              busy,
    output logic                     rf_we,
    output logic [4:0]               rf_wa,
    output logic [XLEN-1:0]          rf_wd,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            from_lsu;
    logic            alu_sel, fifo_empty, lsu_take, pop, bypass, push;
    logic [31:0]     busy_next;

    // Ready looks only at the occupancy register so it never forms a loop with valid.
    assign lsu_ready  = (fifo_count != FULL);
    assign fifo_empty = (fifo_count == '0);

    always_comb begin
        alu_sel  = alu_valid && (alu_rd != 5'd0);
        lsu_take = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
        pop      = !alu_sel && !fifo_empty;
        bypass   = !alu_sel && fifo_empty && lsu_take;
        push     = lsu_take && !bypass;
    end

    // Clear happens on the commit edge of an LSU-sourced write; a same-edge set wins.
    always_comb begin
        busy_next = busy;
        if (rf_we && from_lsu)
            busy_next[rf_wa] = 1'b0;
        if (issue_valid && (issue_rd != 5'd0))
            busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{rd: lsu_rd, data: lsu_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            busy       <= '0;
            rf_we      <= 1'b0;
            rf_wa      <= '0;
            rf_wd      <= '0;
            from_lsu   <= 1'b0;
        end else begin
            busy <= busy_next;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase

            if (alu_sel) begin
                rf_we    <= 1'b1;
                rf_wa    <= alu_rd;
                rf_wd    <= alu_data;
                from_lsu <= 1'b0;
            end else if (pop) begin
                rf_we    <= 1'b1;
                rf_wa    <= mem[rd_ptr].rd;
                rf_wd    <= mem[rd_ptr].data;
                from_lsu <= 1'b1;
            end else if (bypass) begin
                rf_we    <= 1'b1;
                rf_wa    <= lsu_rd;
                rf_wd    <= lsu_data;
                from_lsu <= 1'b1;
            end else begin
                rf_we    <= 1'b0;
                from_lsu <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: stimulus queues expected register-file writes,
// a negedge monitor pops and compares every write the DUT presents.
module tb_wb_arbiter;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              alu_valid, lsu_valid, issue_valid;
    logic [4:0]        alu_rd, lsu_rd, issue_rd;
    logic [XLEN-1:0]   alu_data, lsu_data;
    logic              lsu_ready;
    logic [31:0]       busy;
    logic              rf_we;
    logic [4:0]        rf_wa;
    logic [XLEN-1:0]   rf_wd;
    logic [$clog2(DEPTH):0] fifo_count;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy(busy), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [XLEN-1:0] data);
        wr_t w;
        w.rd = rd;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
    endtask

    // Scoreboard monitor: every presented write must match the oldest expectation.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got wa=%0d wd=0x%0h expected no write", rf_wa, rf_wd);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", 64'(rf_wa), 64'(w.rd));
                chk("wr_data", 64'(rf_wd), 64'(w.data));
            end
        end
    end

    initial begin
        idle();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_wa", 64'(rf_wa), 64'd0);
        chk("rst_wd", 64'(rf_wd), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ready", 64'(lsu_ready), 64'd1);
        step();

        // ALU/LSU conflict: ALU first, LSU result buffered and written next
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h22;
        expect_wr(5'd5, 32'h11);
        expect_wr(5'd6, 32'h22);
        step(); idle();
        @(negedge clk);
        chk("conf_count1", 64'(fifo_count), 64'd1);
        step();
        @(negedge clk);
        chk("conf_count0", 64'(fifo_count), 64'd0);
        chk("conf_we2", 64'(rf_we), 64'd1);
        step();

        // LSU bypass and busy lifetime
        issue_valid = 1'b1; issue_rd = 5'd7;
        step(); idle();
        @(negedge clk);
        chk("byp_busy_set", 64'(busy), 64'h80);
        step(); step();
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hABCD;
        expect_wr(5'd7, 32'hABCD);
        step(); idle();
        @(negedge clk);
        chk("byp_we", 64'(rf_we), 64'd1);
        chk("byp_busy_hold", 64'(busy[7]), 64'd1);
        chk("byp_count", 64'(fifo_count), 64'd0);
        step();
        @(negedge clk);
        chk("byp_busy_clr", 64'(busy[7]), 64'd0);
        chk("byp_we_off", 64'(rf_we), 64'd0);

        // Backpressure: ALU every cycle, 5 LSU offers, only 4 fit
        for (int i = 0; i < 5; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA0 + 32'(i);
            lsu_valid = 1'b1; lsu_rd = 5'(10 + i); lsu_data = 32'h100 + 32'(i);
            expect_wr(5'd1, 32'hA0 + 32'(i));
            step();
        end
        idle();
        for (int i = 0; i < 4; i++)
            expect_wr(5'(10 + i), 32'h100 + 32'(i));
        @(negedge clk);
        chk("bp_count_full", 64'(fifo_count), 64'd4);
        chk("bp_ready_low", 64'(lsu_ready), 64'd0);
        for (int i = 0; i < 4; i++)
            step();
        @(negedge clk);
        chk("bp_count_drain", 64'(fifo_count), 64'd0);
        chk("bp_ready_high", 64'(lsu_ready), 64'd1);
        step();

        // x0: ALU to x0 does not block the FIFO pop
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h55;
        lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'h66;
        expect_wr(5'd2, 32'h55);
        step(); idle();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
        expect_wr(5'd12, 32'h66);
        step(); idle();
        @(negedge clk);
        chk("x0_alu_pop_wa", 64'(rf_wa), 64'd12);
        chk("x0_alu_count", 64'(fifo_count), 64'd0);
        step();

        // x0: LSU result to x0 is accepted and dropped
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h77;
        @(negedge clk);
        chk("x0_lsu_ready", 64'(lsu_ready), 64'd1);
        step(); idle();
        @(negedge clk);
        chk("x0_lsu_we", 64'(rf_we), 64'd0);
        chk("x0_lsu_count", 64'(fifo_count), 64'd0);
        step();

        // x0: issue to x0 never marks busy
        issue_valid = 1'b1; issue_rd = 5'd0;
        step(); idle();
        @(negedge clk);
        chk("x0_issue_busy", 64'(busy), 64'd0);
        step();

        // Same-edge set and clear of x3: set wins
        issue_valid = 1'b1; issue_rd = 5'd3;
        step(); idle();
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33;
        expect_wr(5'd3, 32'h33);
        step(); idle();
        issue_valid = 1'b1; issue_rd = 5'd3;
        @(negedge clk);
        chk("same_we", 64'(rf_we), 64'd1);
        step(); idle();
        @(negedge clk);
        chk("same_busy3", 64'(busy[3]), 64'd1);
        step();

        // Reset mid-operation with three buffered results and a pending bit
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hC0 + 32'(i);
            lsu_valid = 1'b1; lsu_rd = 5'(20 + i); lsu_data = 32'h200 + 32'(i);
            issue_valid = 1'b1; issue_rd = 5'd9;
            expect_wr(5'd4, 32'hC0 + 32'(i));
            step();
        end
        idle();
        @(negedge clk);
        chk("mid_count3", 64'(fifo_count), 64'd3);
        chk("mid_busy_pre", 64'(busy[9]), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_count", 64'(fifo_count), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_we", 64'(rf_we), 64'd0);
        chk("mid_rst_ready", 64'(lsu_ready), 64'd1);
        for (int i = 0; i < 4; i++)
            step();
        @(negedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
